membrane_potential_bank: RTL and testbench
==========================================

# membrane_potential_bank

- Holds membrane potential and decay rate for NUM_NEURONS neurons.
- On each timestep `clear`, sweeps every neuron in address order: issues the stored potential to the decay unit over a valid/ready request channel, then writes the returned decayed value back in place.
- Sits between the synaptic accumulator (writer of potentials) and the potential decay unit (consumer of potential/address/rate); it is the issuing/collecting end of the decay interface.

## Interface
Parameters:
- NUM_NEURONS, 16: neurons stored; addresses 0..NUM_NEURONS-1.
- ADDR_W, 12: neuron address width.
- DATA_W, 32: IEEE-754 single potential width.

Ports:
- CLK  in  1: single clock; all logic on rising edge.
- RESET  in  1: synchronous, active-high.
- clear  in  1: timestep boundary; rising edge starts a sweep.
- cfg_we  in  1: initialization write strobe.
- cfg_addr  in  ADDR_W: initialization address.
- cfg_potential  in  DATA_W: initial potential.
- cfg_decay_rate  in  5: per-neuron decay rate code.
- acc_we  in  1: accumulator potential write strobe.
- acc_addr  in  ADDR_W: accumulator write address.
- acc_potential  in  DATA_W: new potential.
- wr_ready  out  1: cfg/acc writes accepted; equals ~busy.
- rd_addr  in  ADDR_W: read address.
- rd_potential  out  DATA_W: registered read data.
- dec_valid  out  1: decay request valid.
- dec_ready  in  1: decay unit accepts request.
- dec_neuron_address  out  ADDR_W: request address.
- dec_membrane_potential  out  DATA_W: request potential.
- dec_decay_rate  out  5: request rate.
- dec_result_valid  in  1: decayed result present.
- dec_result  in  DATA_W: decayed potential.
- busy  out  1: sweep in progress.
- sweep_done  out  1: one-cycle pulse at sweep end.
- clear_overrun  out  1: one-cycle pulse; clear edge arrived while busy.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE → ISSUE on a clear rising edge (clear & ~clear_q); address counter = 0.
- ISSUE: dec_valid=1; payload taken from entry[counter], held stable until dec_ready. On dec_valid&dec_ready → WAIT.
- WAIT: on dec_result_valid, write dec_result to entry[counter].
  - If counter == NUM_NEURONS-1 → DONE; else counter+1 → ISSUE.
- DONE: sweep_done=1 → IDLE.
- dec_result_valid outside WAIT is ignored; at most one request outstanding.
- Writes:
  - Accepted only when wr_ready=1.
  - acc_we updates the potential only; cfg_we updates potential and rate.
  - cfg_we and acc_we together on the same address: cfg wins.
  - Writes while busy are dropped.
  - Address ≥ NUM_NEURONS: write ignored; read returns 0.
- Clear rising edge while busy: sweep unaffected; clear_overrun pulses.
- Rate codes are passed through uninterpreted (1, 2, 4, 8 = divide; 3 = ×0.75; other = identity).

## Timing
- Reset values:
  - All outputs 0; FSM IDLE; counter 0; clear_q 0.
  - All potentials 0x00000000; all rates 5'd1.
- Reset mid-sweep aborts immediately: no further writes, no sweep_done.
- Clear edge sampled in cycle T:
  - busy=1 and dec_valid=1 from T+1.
  - sweep_done in the cycle after the last write-back; busy=0 the cycle after that.
- Minimum per neuron: 2 cycles (ISSUE with ready, WAIT with result). Minimum sweep: 2·NUM_NEURONS+1 cycles after start.
- Write accepted in cycle T is visible on rd_potential at T+1 (rd_addr given at T+1) and to a sweep starting at T+1.
- Sweep write-back in cycle T is visible on rd_potential at T+1.
- Write address equal to rd_addr in the same cycle: the read returns the old value.

## Structure
- Shared package `neuron_pkg`:
  - State enum.
  - Rate constants: RATE_DIV1=1, RATE_DIV2=2, RATE_MUL075=3, RATE_DIV4=4, RATE_DIV8=8.
  - DATA_W, ADDR_W, RATE_W=5.
- One natural sub-module, `membrane_potential_ram`: register array with one write port and one registered read port, plus an asynchronous read for the issue payload; sync reset clears it to the reset values.
- The FSM, counter and edge detector stay in the top.

## Test plan
- Reset, then read all addresses: every rd_potential = 0x00000000; busy=0, dec_valid=0.
- cfg addr 3 = 0x41200000 (10.0), rate 2; clear edge; model returns 0x40A00000 on addr 3 → read addr 3 = 0x40A00000; other addresses unchanged; sweep_done exactly once.
- Decay model holds dec_ready low 5 cycles per request: payload stays stable; addresses issued 0..15 in order; no duplicate writes.
- acc_we asserted while busy: wr_ready=0, value dropped; after sweep_done, acc_we addr 7 = 0x3F800000 is written and read back.
- Second clear edge mid-sweep → one clear_overrun pulse, sweep completes normally; RESET mid-sweep → busy=0 next cycle, no sweep_done.
- Spurious dec_result_valid in IDLE/ISSUE is ignored; a write to addr 20 is ignored and read of addr 20 returns 0.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and constants for the neuron potential storage and decay path.
package neuron_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 12;
  localparam int RATE_W = 5;

  // Rate codes are carried through the bank untouched; the decay unit interprets them.
  localparam logic [RATE_W-1:0] RATE_DIV1   = 5'd1;
  localparam logic [RATE_W-1:0] RATE_DIV2   = 5'd2;
  localparam logic [RATE_W-1:0] RATE_MUL075 = 5'd3;
  localparam logic [RATE_W-1:0] RATE_DIV4   = 5'd4;
  localparam logic [RATE_W-1:0] RATE_DIV8   = 5'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/membrane_potential_ram.sv
// Potential/rate register array: one write port, one registered read port and an
// asynchronous read used as the decay request payload.
module membrane_potential_ram #(
  parameter int NUM_NEURONS = 16,
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_we,
  input  logic                          i_rate_we,
  input  logic [ADDR_W-1:0]             i_waddr,
  input  logic [DATA_W-1:0]             i_wdata,
  input  logic [neuron_pkg::RATE_W-1:0] i_wrate,
  input  logic [ADDR_W-1:0]             i_raddr,
  output logic [DATA_W-1:0]             o_rdata,
  input  logic [ADDR_W-1:0]             i_aaddr,
  output logic [DATA_W-1:0]             o_apot,
  output logic [neuron_pkg::RATE_W-1:0] o_arate
);

  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(NUM_NEURONS);

  logic [DATA_W-1:0]             r_pot  [NUM_NEURONS];
  logic [neuron_pkg::RATE_W-1:0] r_rate [NUM_NEURONS];
  logic [DATA_W-1:0]             r_rdata;

  logic             w_wr_hit;
  logic             w_rd_hit;
  logic             w_a_hit;
  logic [IDX_W-1:0] w_widx;
  logic [IDX_W-1:0] w_ridx;
  logic [IDX_W-1:0] w_aidx;

  // Out-of-range addresses never alias onto a real entry: writes drop, reads give 0.
  assign w_wr_hit = (i_waddr < LIMIT);
  assign w_rd_hit = (i_raddr < LIMIT);
  assign w_a_hit  = (i_aaddr < LIMIT);
  assign w_widx   = i_waddr[IDX_W-1:0];
  assign w_ridx   = i_raddr[IDX_W-1:0];
  assign w_aidx   = i_aaddr[IDX_W-1:0];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_pot[i]  <= '0;
        r_rate[i] <= neuron_pkg::RATE_DIV1;
      end
      r_rdata <= '0;
    end else begin
      if (i_we && w_wr_hit) begin
        r_pot[w_widx] <= i_wdata;
      end
      if (i_rate_we && w_wr_hit) begin
        r_rate[w_widx] <= i_wrate;
      end
      r_rdata <= w_rd_hit ? r_pot[w_ridx] : '0;
    end
  end

  assign o_rdata = r_rdata;
  assign o_apot  = w_a_hit ? r_pot[w_aidx]  : '0;
  assign o_arate = w_a_hit ? r_rate[w_aidx] : '0;

endmodule

// File: rtl/membrane_potential_bank.sv
// Per-neuron potential/rate store that, on each timestep clear edge, sends every
// potential through the decay unit in address order and writes the result back.
module membrane_potential_bank #(
  parameter int NUM_NEURONS = 16,
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          clear,
  input  logic                          cfg_we,
  input  logic [ADDR_W-1:0]             cfg_addr,
  input  logic [DATA_W-1:0]             cfg_potential,
  input  logic [neuron_pkg::RATE_W-1:0] cfg_decay_rate,
  input  logic                          acc_we,
  input  logic [ADDR_W-1:0]             acc_addr,
  input  logic [DATA_W-1:0]             acc_potential,
  output logic                          wr_ready,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic [DATA_W-1:0]             rd_potential,
  output logic                          dec_valid,
  input  logic                          dec_ready,
  output logic [ADDR_W-1:0]             dec_neuron_address,
  output logic [DATA_W-1:0]             dec_membrane_potential,
  output logic [neuron_pkg::RATE_W-1:0] dec_decay_rate,
  input  logic                          dec_result_valid,
  input  logic [DATA_W-1:0]             dec_result,
  output logic                          busy,
  output logic                          sweep_done,
  output logic                          clear_overrun,
  output neuron_pkg::state_e            o_dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_NEURONS - 1);

  neuron_pkg::state_e r_state;
  logic [ADDR_W-1:0]  r_counter;
  logic               r_clear_q;
  logic               r_dec_valid;
  logic               r_busy;
  logic               r_sweep_done;
  logic               r_clear_overrun;

  logic                          w_clear_edge;
  logic                          w_sweep_we;
  logic                          w_host_ok;
  logic                          w_ram_we;
  logic                          w_rate_we;
  logic [ADDR_W-1:0]             w_waddr;
  logic [DATA_W-1:0]             w_wdata;
  logic [neuron_pkg::RATE_W-1:0] w_wrate;

  assign w_clear_edge = clear & ~r_clear_q;
  assign w_sweep_we   = (r_state == neuron_pkg::WAIT) & dec_result_valid;
  assign w_host_ok    = ~r_busy;

  // Host writes only reach the array while idle, so they can never collide with a
  // sweep write-back; cfg takes the single write port when both strobes are high.
  always_comb begin
    w_ram_we  = 1'b0;
    w_rate_we = 1'b0;
    w_waddr   = '0;
    w_wdata   = '0;
    w_wrate   = cfg_decay_rate;
    if (w_sweep_we) begin
      w_ram_we = 1'b1;
      w_waddr  = r_counter;
      w_wdata  = dec_result;
    end else if (w_host_ok && cfg_we) begin
      w_ram_we  = 1'b1;
      w_rate_we = 1'b1;
      w_waddr   = cfg_addr;
      w_wdata   = cfg_potential;
    end else if (w_host_ok && acc_we) begin
      w_ram_we = 1'b1;
      w_waddr  = acc_addr;
      w_wdata  = acc_potential;
    end
  end

  membrane_potential_ram #(
    .NUM_NEURONS (NUM_NEURONS),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W)
  ) u_ram (
    .i_clk     (CLK),
    .i_reset   (RESET),
    .i_we      (w_ram_we),
    .i_rate_we (w_rate_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_wrate   (w_wrate),
    .i_raddr   (rd_addr),
    .o_rdata   (rd_potential),
    .i_aaddr   (r_counter),
    .o_apot    (dec_membrane_potential),
    .o_arate   (dec_decay_rate)
  );

  // Decay channel: dec_valid rises with the payload of entry[counter]; the payload
  // holds until the edge where dec_valid & dec_ready are both high (the transfer).
  // One request is outstanding at a time and results are taken only in WAIT.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state         <= neuron_pkg::IDLE;
      r_counter       <= '0;
      r_clear_q       <= 1'b0;
      r_dec_valid     <= 1'b0;
      r_busy          <= 1'b0;
      r_sweep_done    <= 1'b0;
      r_clear_overrun <= 1'b0;
    end else begin
      r_clear_q       <= clear;
      r_sweep_done    <= 1'b0;
      r_clear_overrun <= w_clear_edge & r_busy;
      case (r_state)
        neuron_pkg::IDLE: begin
          if (w_clear_edge) begin
            r_state     <= neuron_pkg::ISSUE;
            r_counter   <= '0;
            r_dec_valid <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        neuron_pkg::ISSUE: begin
          if (r_dec_valid && dec_ready) begin
            r_state     <= neuron_pkg::WAIT;
            r_dec_valid <= 1'b0;
          end
        end
        neuron_pkg::WAIT: begin
          if (dec_result_valid) begin
            if (r_counter == LAST_ADDR) begin
              r_state      <= neuron_pkg::DONE;
              r_sweep_done <= 1'b1;
            end else begin
              r_state     <= neuron_pkg::ISSUE;
              r_counter   <= r_counter + ADDR_W'(1);
              r_dec_valid <= 1'b1;
            end
          end
        end
        neuron_pkg::DONE: begin
          r_state <= neuron_pkg::IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state     <= neuron_pkg::IDLE;
          r_dec_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign wr_ready           = ~r_busy;
  assign busy               = r_busy;
  assign dec_valid          = r_dec_valid;
  assign dec_neuron_address = r_counter;
  assign sweep_done         = r_sweep_done;
  assign clear_overrun      = r_clear_overrun;
  assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_membrane_potential_bank.sv
// Directed bench for membrane_potential_bank with a scripted decay-unit responder.
module tb_membrane_potential_bank;

  localparam int N  = 16;
  localparam int AW = 12;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  logic          clear = 1'b0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [DW-1:0] cfg_potential = '0;
  logic [4:0]    cfg_decay_rate = '0;
  logic          acc_we = 1'b0;
  logic [AW-1:0] acc_addr = '0;
  logic [DW-1:0] acc_potential = '0;
  logic          wr_ready;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_potential;
  logic          dec_valid;
  logic          dec_ready;
  logic [AW-1:0] dec_neuron_address;
  logic [DW-1:0] dec_membrane_potential;
  logic [4:0]    dec_decay_rate;
  logic          dec_result_valid;
  logic [DW-1:0] dec_result;
  logic          busy;
  logic          sweep_done;
  logic          clear_overrun;
  neuron_pkg::state_e dbg_state;

  membrane_potential_bank #(.NUM_NEURONS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK                    (CLK),
    .RESET                  (RESET),
    .clear                  (clear),
    .cfg_we                 (cfg_we),
    .cfg_addr               (cfg_addr),
    .cfg_potential          (cfg_potential),
    .cfg_decay_rate         (cfg_decay_rate),
    .acc_we                 (acc_we),
    .acc_addr               (acc_addr),
    .acc_potential          (acc_potential),
    .wr_ready               (wr_ready),
    .rd_addr                (rd_addr),
    .rd_potential           (rd_potential),
    .dec_valid              (dec_valid),
    .dec_ready              (dec_ready),
    .dec_neuron_address     (dec_neuron_address),
    .dec_membrane_potential (dec_membrane_potential),
    .dec_decay_rate         (dec_decay_rate),
    .dec_result_valid       (dec_result_valid),
    .dec_result             (dec_result),
    .busy                   (busy),
    .sweep_done             (sweep_done),
    .clear_overrun          (clear_overrun),
    .o_dbg_state            (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int ov_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mdl_pot [N];
  logic [4:0]  mdl_rate [N];

  always @(posedge CLK) cyc++;
  always @(negedge CLK) begin
    if (sweep_done) done_cnt++;
    if (clear_overrun) ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Hand-written decay behaviour of the stand-in unit: address 3 decays 10.0 -> 5.0,
  // every other address comes back unchanged.
  function automatic logic [31:0] decay_fn(input int a, input logic [31:0] p);
    return (a == 3) ? 32'h40A00000 : p;
  endfunction

  // ---------------- decay-unit responder ----------------
  int          ready_delay = 0;
  bit          spur_en = 1'b0;
  int          stall_cnt = 0;
  bit          rsp_due = 1'b0;
  logic [31:0] rsp_val = '0;
  logic [31:0] hold_addr, hold_pot, hold_rate;
  int          stab_bad = 0;
  int          log_n = 0;
  logic [31:0] log_addr [256];
  logic [31:0] log_pot  [256];
  logic [31:0] log_rate [256];

  initial begin
    dec_ready = 1'b0;
    dec_result_valid = 1'b0;
    dec_result = '0;
    forever begin
      @(posedge CLK); #1;
      dec_ready = 1'b0;
      dec_result_valid = 1'b0;
      if (rsp_due) begin
        dec_result_valid = 1'b1;
        dec_result = rsp_val;
        rsp_due = 1'b0;
      end else begin
        if (spur_en) begin
          dec_result_valid = 1'b1;
          dec_result = 32'hDEADBEEF;
        end
        if (!dec_valid) begin
          stall_cnt = 0;
        end else begin
          if (stall_cnt == 0) begin
            hold_addr = 32'(dec_neuron_address);
            hold_pot  = dec_membrane_potential;
            hold_rate = 32'(dec_decay_rate);
          end else if (hold_addr != 32'(dec_neuron_address) || hold_pot != dec_membrane_potential ||
                       hold_rate != 32'(dec_decay_rate)) begin
            stab_bad++;
          end
          if (stall_cnt >= ready_delay) begin
            dec_ready = 1'b1;
            log_addr[log_n % 256] = 32'(dec_neuron_address);
            log_pot[log_n % 256]  = dec_membrane_potential;
            log_rate[log_n % 256] = 32'(dec_decay_rate);
            log_n++;
            rsp_val = decay_fn(int'(dec_neuron_address), dec_membrane_potential);
            rsp_due = 1'b1;
            stall_cnt = 0;
          end else begin
            stall_cnt++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cfg_write(input logic [AW-1:0] a, input logic [DW-1:0] p, input logic [4:0] r,
                           output logic rdy);
    @(posedge CLK); #1;
    cfg_we = 1'b1; cfg_addr = a; cfg_potential = p; cfg_decay_rate = r;
    rdy = wr_ready;
    @(posedge CLK); #1;
    cfg_we = 1'b0;
  endtask

  task automatic acc_write(input logic [AW-1:0] a, input logic [DW-1:0] p, output logic rdy);
    @(posedge CLK); #1;
    acc_we = 1'b1; acc_addr = a; acc_potential = p;
    rdy = wr_ready;
    @(posedge CLK); #1;
    acc_we = 1'b0;
  endtask

  task automatic rd_check(input int a, input logic [31:0] e);
    @(posedge CLK); #1;
    rd_addr = AW'(a);
    @(posedge CLK); #1;
    check($sformatf("rd[%0d]", a), rd_potential, e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mdl_pot[i] = '0;
      mdl_rate[i] = 5'd1;
    end
  endtask

  task automatic read_all();
    for (int i = 0; i < N; i++) rd_check(i, mdl_pot[i]);
  endtask

  int sw_base, sw_d0, sw_t0, sw_dly;

  task automatic start_sweep(input int dly);
    ready_delay = dly;
    sw_dly = dly;
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(32'(i));
    sw_base = log_n;
    sw_d0 = done_cnt;
    @(posedge CLK); #1;
    clear = 1'b1;
    @(posedge CLK); #1;
    clear = 1'b0;
    sw_t0 = cyc;
    check("busy_after_clear", 32'(busy), 1);
    check("dec_valid_after_clear", 32'(dec_valid), 1);
  endtask

  task automatic finish_sweep();
    for (int k = 0; k < 3000; k++) begin
      @(negedge CLK);
      if (sweep_done) break;
    end
    check("sweep_done_seen", 32'(sweep_done), 1);
    // ISSUE stalls dly cycles, then one accept cycle and one WAIT cycle per neuron.
    check("sweep_latency", 32'(cyc - sw_t0), 32'((sw_dly + 2) * N));
    @(negedge CLK);
    check("busy_after_done", 32'(busy), 0);
    check("sweep_done_width", 32'(sweep_done), 0);
    check("sweep_done_count", 32'(done_cnt - sw_d0), 1);
    check("request_count", 32'(log_n - sw_base), 32'(N));
    for (int i = 0; i < N; i++) begin
      logic [31:0] ea;
      ea = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFFFFFF;
      check($sformatf("req_addr[%0d]", i), log_addr[(sw_base + i) % 256], ea);
      check($sformatf("req_pot[%0d]", i), log_pot[(sw_base + i) % 256], mdl_pot[i]);
      check($sformatf("req_rate[%0d]", i), log_rate[(sw_base + i) % 256], 32'(mdl_rate[i]));
    end
    for (int i = 0; i < N; i++) mdl_pot[i] = decay_fn(i, mdl_pot[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic rdy;
    int o0, d0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("reset_busy", 32'(busy), 0);
    check("reset_dec_valid", 32'(dec_valid), 0);
    check("reset_wr_ready", 32'(wr_ready), 1);
    check("reset_sweep_done", 32'(sweep_done), 0);
    check("reset_overrun", 32'(clear_overrun), 0);
    read_all();

    // First sweep: 10.0 at addr 3 with rate 2 comes back as 5.0.
    cfg_write(3, 32'h41200000, 5'd2, rdy);
    check("cfg3_ready", 32'(rdy), 1);
    mdl_pot[3] = 32'h41200000; mdl_rate[3] = 5'd2;
    cfg_write(7, 32'h40490FDB, 5'd1, rdy);
    mdl_pot[7] = 32'h40490FDB;
    start_sweep(0);
    finish_sweep();
    check("no_overrun_single_clear", 32'(ov_cnt), 0);
    read_all();

    // Stalled sweep with dropped writes and a second clear edge mid-sweep.
    o0 = ov_cnt;
    start_sweep(5);
    repeat (20) @(posedge CLK);
    acc_write(7, 32'h12345678, rdy);
    check("acc_ready_busy", 32'(rdy), 0);
    cfg_write(9, 32'h55555555, 5'd8, rdy);
    check("cfg_ready_busy", 32'(rdy), 0);
    @(posedge CLK); #1 clear = 1'b1;
    @(posedge CLK); #1 clear = 1'b0;
    finish_sweep();
    check("payload_stable", 32'(stab_bad), 0);
    check("overrun_count", 32'(ov_cnt - o0), 1);
    rd_check(7, mdl_pot[7]);
    rd_check(9, mdl_pot[9]);

    // Write to the address being read: old value first, new value next cycle.
    @(posedge CLK); #1 rd_addr = 7;
    acc_write(7, 32'h3F800000, rdy);
    check("acc7_ready", 32'(rdy), 1);
    check("rd_same_cycle_old", rd_potential, 32'h40490FDB);
    @(posedge CLK); #1;
    check("rd_after_write", rd_potential, 32'h3F800000);
    mdl_pot[7] = 32'h3F800000;

    // cfg and acc to the same address together: cfg wins, rate 4 stored.
    @(posedge CLK); #1;
    cfg_we = 1'b1; cfg_addr = 5; cfg_potential = 32'h11111111; cfg_decay_rate = 5'd4;
    acc_we = 1'b1; acc_addr = 5; acc_potential = 32'h22222222;
    @(posedge CLK); #1;
    cfg_we = 1'b0; acc_we = 1'b0;
    mdl_pot[5] = 32'h11111111; mdl_rate[5] = 5'd4;
    rd_check(5, 32'h11111111);

    // Out-of-range writes and reads.
    cfg_write(20, 32'hCAFEBABE, 5'd8, rdy);
    acc_write(31, 32'hBADC0FFE, rdy);
    rd_check(20, 32'h0);
    rd_check(4, mdl_pot[4]);
    rd_check(15, mdl_pot[15]);

    // Spurious results in IDLE and during ISSUE stalls must be ignored.
    spur_en = 1'b1;
    repeat (5) @(posedge CLK);
    start_sweep(2);
    finish_sweep();
    spur_en = 1'b0;
    read_all();

    // Reset in the middle of a sweep.
    start_sweep(3);
    repeat (10) @(posedge CLK);
    d0 = done_cnt;
    #1 RESET = 1'b1;
    @(posedge CLK); #1;
    check("busy_after_mid_reset", 32'(busy), 0);
    check("dec_valid_after_mid_reset", 32'(dec_valid), 0);
    RESET = 1'b0;
    exp_q.delete();
    repeat (50) @(posedge CLK);
    check("no_done_after_reset", 32'(done_cnt - d0), 0);
    model_reset();
    rd_check(3, 32'h0);
    rd_check(5, 32'h0);
    rd_check(7, 32'h0);

    // Fresh sweep after reset sees zero potentials and default rates.
    start_sweep(0);
    finish_sweep();
    rd_check(3, 32'h40A00000);
    rd_check(0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
